mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one memory-side request/data port pair between two masters: requester 0 (CPU data port) and requester 1 (DMA engine). Read and write channels are arbitrated independently, round-robin on contention. A grant stays locked from request handshake until the last data beat of that burst. Sits between the masters and the memory interface and is the only driver of the downstream port.

## Interface
- NREQ, 2 (fixed), number of requesters; index 0 = CPU, index 1 = DMA
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- m_rd_req_addr  in  64  per-requester read address, requester i at [32i+31:32i]
- m_rd_req_len  in  10  per-requester read burst length−1, [5i+4:5i]
- m_rd_req_valid  in  2 / m_rd_req_ready  out  2
- m_rd_rdata  out  32  broadcast to both requesters
- m_rd_valid  out  2 / m_rd_last  out  2 / m_rd_ready  in  2
- m_wr_req_addr  in  64 / m_wr_req_len  in  10 / m_wr_req_valid  in  2 / m_wr_req_ready  out  2
- m_wr_data  in  64 / m_wr_valid  in  2 / m_wr_last  in  2 / m_wr_ready  out  2
- s_rd_req_addr  out  32 / s_rd_req_len  out  5 / s_rd_req_valid  out  1 / s_rd_req_ready  in  1
- s_rd_rdata  in  32 / s_rd_valid  in  1 / s_rd_last  in  1 / s_rd_ready  out  1
- s_wr_req_addr  out  32 / s_wr_req_len  out  5 / s_wr_req_valid  out  1 / s_wr_req_ready  in  1
- s_wr_data  out  32 / s_wr_valid  out  1 / s_wr_last  out  1 / s_wr_ready  in  1
- rd_grant  out  2  one-hot current read owner (0 when idle)
- wr_grant  out  2  one-hot current write owner
- len_err  out  1  sticky: burst ended with beat count ≠ len+1

## Operation
- Read FSM per channel: IDLE → REQ → DATA → IDLE; write FSM identical, independent.
- IDLE: if any m_*_req_valid, register grant; one requester valid → it wins; both → the one that did not win last on this channel. last_winner resets to 1 (CPU wins first contention).
- REQ: s_*_req_{addr,len,valid} = granted requester's fields; m_*_req_ready[g] = s_*_req_ready, other requester's ready = 0. valid&ready → DATA. Granted valid drops before handshake → IDLE, no transfer, last_winner unchanged.
- DATA (read): s_rd_ready = m_rd_ready[g]; m_rd_valid[g] = s_rd_valid, m_rd_last[g] = s_rd_last, others 0. Beat handshake with last → IDLE, last_winner ← g.
- DATA (write): s_wr_{data,valid,last} from granted requester; m_wr_ready[g] = s_wr_ready. Last beat handshake → IDLE.
- 5-bit beat counter per channel cleared on REQ→DATA, incremented per beat. On last beat, count ≠ latched len → len_err set (sticky until rst). Last never asserted → stays in DATA.
- Non-granted requester's valid is held off; its signals are never forwarded.

## Timing
- Reset: both FSMs IDLE, grants 0, all s_*_valid/ready and m_*_ready/valid outputs 0, len_err 0, last_winner 1.
- Arbitration takes one IDLE cycle: request presented at cycle t appears on s_*_req_valid at t+1 at the earliest.
- Request and data paths are combinational through the arbiter once granted; no added beat latency, full throughput per beat.
- Back-to-back bursts: at least one IDLE cycle between bursts on a channel.
- Read and write may be owned by different requesters simultaneously.
- rst mid-burst: immediate return to IDLE; downstream transaction abandoned (memory reset together).

## Structure
- Shared package: state encodings (S_IDLE, S_REQ, S_DATA), REQ_CPU=0, REQ_DMA=1.
- One sub-module, chan_arb, instantiated twice (read, write): FSM, grant, last_winner, beat counter; top does muxing/demuxing.

## Test plan
- Single DMA read len=7: grant=2'b10 at t+1, 8 beats routed to m_rd_valid[1], IDLE after last, len_err=0.
- Simultaneous reads from both after reset → CPU served first, DMA second; repeat contention → alternates DMA, CPU.
- CPU write len=3 concurrent with DMA read len=7 → both proceed, wr_grant=01, rd_grant=10, no cross-routing.
- Downstream s_rd_req_ready low 5 cycles → grant held, other requester's ready stays 0.
- s_rd_last on beat 4 of len=7 → len_err=1, FSM IDLE, next burst served normally.
- rst asserted during DATA beat 3 → next cycle grants 0, all valids 0; fresh request granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
// Channel FSM encoding, requester indices and a one-hot grant helper.
package mem_port_arbiter_pkg;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 5;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2
  } chan_state_e;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_chan_arb.sv
// Per-channel arbiter: round-robin grant, burst lock FSM and beat-count check.
// Used once for the read channel and once for the write channel.
module mem_port_arbiter_chan_arb
  import mem_port_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic                  req_ready,
  input  logic                  beat,
  input  logic                  beat_last,
  output chan_state_e           state,
  output logic [NREQ-1:0]       grant,
  output logic                  gidx,
  output logic                  len_err
);

  chan_state_e      state_q, state_d;
  logic             gidx_q, gidx_d;
  logic             last_winner_q, last_winner_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gidx_q        <= REQ_CPU;
      last_winner_q <= REQ_DMA;
      len_q         <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      gidx_q        <= gidx_d;
      last_winner_q <= last_winner_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gidx_d        = gidx_q;
    last_winner_d = last_winner_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d = S_REQ;
          // On contention the requester that did not finish the previous burst wins.
          if (&req_valid) gidx_d = ~last_winner_q;
          else            gidx_d = req_valid[REQ_DMA];
        end
      end
      S_REQ: begin
        if (!req_valid[gidx_q]) begin
          state_d = S_IDLE;
        end else if (req_ready) begin
          state_d = S_DATA;
          cnt_d   = '0;
          len_d   = gidx_q ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
        end
      end
      S_DATA: begin
        if (beat) begin
          cnt_d = cnt_q + 5'd1;
          if (beat_last) begin
            if (cnt_q != len_q) err_d = 1'b1;
            last_winner_d = gidx_q;
            state_d       = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state   = state_q;
  assign gidx    = gidx_q;
  assign grant   = (state_q == S_IDLE) ? '0 : idx_to_onehot(gidx_q);
  assign len_err = err_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory read/write port pair between the CPU data port and the DMA engine.
// Channels arbitrate independently; this level only steers fields to and from the owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ*ADDR_W-1:0] m_rd_req_addr,
  input  logic [NREQ*LEN_W-1:0]  m_rd_req_len,
  input  logic [NREQ-1:0]        m_rd_req_valid,
  output logic [NREQ-1:0]        m_rd_req_ready,
  output logic [DATA_W-1:0]      m_rd_rdata,
  output logic [NREQ-1:0]        m_rd_valid,
  output logic [NREQ-1:0]        m_rd_last,
  input  logic [NREQ-1:0]        m_rd_ready,
  input  logic [NREQ*ADDR_W-1:0] m_wr_req_addr,
  input  logic [NREQ*LEN_W-1:0]  m_wr_req_len,
  input  logic [NREQ-1:0]        m_wr_req_valid,
  output logic [NREQ-1:0]        m_wr_req_ready,
  input  logic [NREQ*DATA_W-1:0] m_wr_data,
  input  logic [NREQ-1:0]        m_wr_valid,
  input  logic [NREQ-1:0]        m_wr_last,
  output logic [NREQ-1:0]        m_wr_ready,
  output logic [ADDR_W-1:0]      s_rd_req_addr,
  output logic [LEN_W-1:0]       s_rd_req_len,
  output logic                   s_rd_req_valid,
  input  logic                   s_rd_req_ready,
  input  logic [DATA_W-1:0]      s_rd_rdata,
  input  logic                   s_rd_valid,
  input  logic                   s_rd_last,
  output logic                   s_rd_ready,
  output logic [ADDR_W-1:0]      s_wr_req_addr,
  output logic [LEN_W-1:0]       s_wr_req_len,
  output logic                   s_wr_req_valid,
  input  logic                   s_wr_req_ready,
  output logic [DATA_W-1:0]      s_wr_data,
  output logic                   s_wr_valid,
  output logic                   s_wr_last,
  input  logic                   s_wr_ready,
  output logic [NREQ-1:0]        rd_grant,
  output logic [NREQ-1:0]        wr_grant,
  output logic                   len_err
);

  chan_state_e rd_state, wr_state;
  logic        rd_gidx, wr_gidx;
  logic        rd_beat, wr_beat;
  logic        rd_len_err, wr_len_err;

  mem_port_arbiter_chan_arb u_rd_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (m_rd_req_valid),
    .req_len   (m_rd_req_len),
    .req_ready (s_rd_req_ready),
    .beat      (rd_beat),
    .beat_last (s_rd_last),
    .state     (rd_state),
    .grant     (rd_grant),
    .gidx      (rd_gidx),
    .len_err   (rd_len_err)
  );

  mem_port_arbiter_chan_arb u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (m_wr_req_valid),
    .req_len   (m_wr_req_len),
    .req_ready (s_wr_req_ready),
    .beat      (wr_beat),
    .beat_last (s_wr_last),
    .state     (wr_state),
    .grant     (wr_grant),
    .gidx      (wr_gidx),
    .len_err   (wr_len_err)
  );

  // Read channel: request forwarded downstream, data beats routed back to the owner only.
  always_comb begin
    s_rd_req_addr  = '0;
    s_rd_req_len   = '0;
    s_rd_req_valid = 1'b0;
    m_rd_req_ready = '0;
    s_rd_ready     = 1'b0;
    m_rd_valid     = '0;
    m_rd_last      = '0;
    if (rd_state == S_REQ) begin
      s_rd_req_addr           = rd_gidx ? m_rd_req_addr[2*ADDR_W-1:ADDR_W]
                                        : m_rd_req_addr[ADDR_W-1:0];
      s_rd_req_len            = rd_gidx ? m_rd_req_len[2*LEN_W-1:LEN_W]
                                        : m_rd_req_len[LEN_W-1:0];
      s_rd_req_valid          = m_rd_req_valid[rd_gidx];
      m_rd_req_ready[rd_gidx] = s_rd_req_ready;
    end
    if (rd_state == S_DATA) begin
      s_rd_ready          = m_rd_ready[rd_gidx];
      m_rd_valid[rd_gidx] = s_rd_valid;
      m_rd_last[rd_gidx]  = s_rd_last;
    end
  end

  assign m_rd_rdata = s_rd_rdata;
  assign rd_beat    = s_rd_valid & s_rd_ready;

  // Write channel: request and data beats forwarded from the owner only.
  always_comb begin
    s_wr_req_addr  = '0;
    s_wr_req_len   = '0;
    s_wr_req_valid = 1'b0;
    m_wr_req_ready = '0;
    s_wr_data      = '0;
    s_wr_valid     = 1'b0;
    s_wr_last      = 1'b0;
    m_wr_ready     = '0;
    if (wr_state == S_REQ) begin
      s_wr_req_addr           = wr_gidx ? m_wr_req_addr[2*ADDR_W-1:ADDR_W]
                                        : m_wr_req_addr[ADDR_W-1:0];
      s_wr_req_len            = wr_gidx ? m_wr_req_len[2*LEN_W-1:LEN_W]
                                        : m_wr_req_len[LEN_W-1:0];
      s_wr_req_valid          = m_wr_req_valid[wr_gidx];
      m_wr_req_ready[wr_gidx] = s_wr_req_ready;
    end
    if (wr_state == S_DATA) begin
      s_wr_data           = wr_gidx ? m_wr_data[2*DATA_W-1:DATA_W] : m_wr_data[DATA_W-1:0];
      s_wr_valid          = m_wr_valid[wr_gidx];
      s_wr_last           = m_wr_last[wr_gidx];
      m_wr_ready[wr_gidx] = s_wr_ready;
    end
  end

  assign wr_beat = s_wr_valid & s_wr_ready;
  assign len_err = rd_len_err | wr_len_err;

endmodule
